// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter state encoding, default parameters
// and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_EMPTY = 2'd3
  } tx_arb_state_e;

  localparam int unsigned UART_BYTE_W            = 8;
  localparam int unsigned TX_ARB_NREQ_DEFAULT    = 4;
  localparam int unsigned TX_ARB_WR_CYC_DEFAULT  = 2;
  localparam int unsigned TX_ARB_TO_CYC_DEFAULT  = 1000;

  // Bits needed to hold the values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after ptr,
// wrapping NREQ-1 -> 0, wins.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NREQ  = TX_ARB_NREQ_DEFAULT,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      pos = IDX_W'((32'(ptr) + off) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters, one byte per grant,
// round-robin. Define UART_ARB_TIMEOUT_EN to enable the WAIT_BUSY timeout/ERR.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ      = TX_ARB_NREQ_DEFAULT,
  parameter int unsigned WR_CYCLES = TX_ARB_WR_CYC_DEFAULT,
  parameter int unsigned TO_CYCLES = TX_ARB_TO_CYC_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             REQ,
  input  logic [UART_BYTE_W*NREQ-1:0] DIN,
  output logic [NREQ-1:0]             GNT,
  input  logic                        TBRE,
  output logic [UART_BYTE_W-1:0]      TDIN,
  output logic                        WRN,
  output logic                        BUSY,
  output logic                        ERR
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned WC_W  = cnt_width(WR_CYCLES);

  // Elaboration-time parameter sanity.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be 2..8");
  end
  if (WR_CYCLES < 1 || TO_CYCLES < 1) begin : g_bad_cycles
    $error("uart_tx_arbiter: WR_CYCLES and TO_CYCLES must be at least 1");
  end

  tx_arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [WC_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [NREQ-1:0]        gnt_d;
  logic [UART_BYTE_W-1:0] tdin_d;
  logic                   wrn_d;

  logic [NREQ-1:0]        win;
  logic [IDX_W-1:0]       win_idx;
  logic [UART_BYTE_W-1:0] din_byte [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_din
    assign din_byte[i] = DIN[UART_BYTE_W*i +: UART_BYTE_W];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (win),
    .idx   (win_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TO_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_d;
`endif

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_cnt_d = wr_cnt_q;
    gnt_d    = '0;
    tdin_d   = TDIN;
    wrn_d    = WRN;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if ((|REQ) && TBRE) begin
          gnt_d    = win;
          tdin_d   = din_byte[win_idx];
          ptr_d    = win_idx;
          wr_cnt_d = '0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        // WRN drops on the first WRITE edge and rises after WR_CYCLES low cycles.
        if (wr_cnt_q == WC_W'(WR_CYCLES)) begin
          wrn_d    = 1'b1;
          wr_cnt_d = '0;
          state_d  = WAIT_BUSY;
        end else begin
          wrn_d    = 1'b0;
          wr_cnt_d = wr_cnt_q + WC_W'(1);
        end
      end
      WAIT_BUSY: begin
        if (!TBRE) begin
          state_d = WAIT_EMPTY;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      WAIT_EMPTY: begin
        if (TBRE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NREQ - 1);
      wr_cnt_q <= '0;
      GNT      <= '0;
      TDIN     <= '0;
      WRN      <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_cnt_q <= wr_cnt_d;
      GNT      <= gnt_d;
      TDIN     <= tdin_d;
      WRN      <= wrn_d;
      BUSY     <= (state_d != IDLE);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // WAIT_BUSY timeout counter and error pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      to_cnt_q <= '0;
      ERR      <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      ERR      <= err_d;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a grant scoreboard and a simple
// transmitter model driving TBRE. Honours UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned WR_CYCLES = 2;
  localparam int unsigned TO_CYCLES = 16;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] DIN;
  logic [3:0]  GNT;
  logic        TBRE;
  logic [7:0]  TDIN;
  logic        WRN;
  logic        BUSY;
  logic        ERR;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   wrn_low     = 0;
  int   tx_cnt      = 0;
  int   rise_cyc    = 0;
  int   rem[4]      = '{0, 0, 0, 0};
  bit   model_en    = 1'b0;
  bit   abort       = 1'b0;
  logic [7:0] tdin_hold = 8'h00;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .WR_CYCLES (WR_CYCLES),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .DIN  (DIN),
    .GNT  (GNT),
    .TBRE (TBRE),
    .TDIN (TDIN),
    .WRN  (WRN),
    .BUSY (BUSY),
    .ERR  (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample #1 after the edge, score grants, track WRN, run TX model.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (GNT !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'(GNT), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("gnt", 32'(GNT), 32'(e.gnt));
        check("tdin", 32'(TDIN), 32'(e.data));
      end
      for (int i = 0; i < 4; i++) begin
        if (GNT[i] === 1'b1 && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) REQ[i] = 1'b0;
        end
      end
    end
    if (WRN === 1'b0) begin
      if (wrn_low == 0) tdin_hold = TDIN;
      else check("tdin_stable", 32'(TDIN), 32'(tdin_hold));
      wrn_low++;
    end else if (wrn_low != 0) begin
      if (abort) begin
        abort = 1'b0;
      end else begin
        check("wrn_width", wrn_low, WR_CYCLES);
        rise_cyc = cyc;
        if (model_en) begin
          TBRE   = 1'b0;
          tx_cnt = 3;
        end
      end
      wrn_low = 0;
    end else if (model_en && tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) TBRE = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (REQ == 4'b0000 && BUSY === 1'b0 && exp_q.size() == 0) break;
    end
    check("done_busy", 32'(BUSY), 32'h0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit err_seen;
    RST  = 1'b0;
    REQ  = 4'b0000;
    DIN  = 32'h0;
    TBRE = 1'b1;

    // Reset values
    repeat (3) step();
    check("rst_wrn", 32'(WRN), 32'h1);
    check("rst_tdin", 32'(TDIN), 32'h0);
    check("rst_gnt", 32'(GNT), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    RST = 1'b1;
    step();

    // Single request from requester 0
    model_en = 1'b1;
    DIN      = 32'h0000_0041;
    rem[0]   = 1;
    push(4'b0001, 8'h41);
    REQ      = 4'b0001;
    wait_done(40);
    check("single_wrn_idle", 32'(WRN), 32'h1);

    // All requesters: order 0,1,2,3,0 from a fresh pointer
    RST = 1'b0;
    step();
    RST = 1'b1;
    DIN = 32'h3332_3130;
    rem = '{2, 1, 1, 1};
    push(4'b0001, 8'h30);
    push(4'b0010, 8'h31);
    push(4'b0100, 8'h32);
    push(4'b1000, 8'h33);
    push(4'b0001, 8'h30);
    REQ = 4'b1111;
    wait_done(200);

    // Transmitter not ready: no grant while TBRE low
    TBRE   = 1'b0;
    rem[1] = 1;
    REQ    = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      check("notrdy_wrn", 32'(WRN), 32'h1);
      check("notrdy_busy", 32'(BUSY), 32'h0);
    end
    push(4'b0010, 8'h31);
    TBRE = 1'b1;
    wait_done(40);

    // Reset during the first WRN-low cycle aborts the write
    rem[0] = 1;
    push(4'b0001, 8'h30);
    REQ = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      if (WRN === 1'b0) break;
    end
    check("abort_wrn_low", 32'(WRN), 32'h0);
    abort = 1'b1;
    RST   = 1'b0;
    step();
    check("abort_wrn", 32'(WRN), 32'h1);
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_gnt", 32'(GNT), 32'h0);
    RST    = 1'b1;
    rem[0] = 1;
    rem[1] = 1;
    push(4'b0001, 8'h30);
    push(4'b0010, 8'h31);
    REQ = 4'b0011;
    wait_done(80);

    // TBRE stuck high after the write
    model_en = 1'b0;
    rem[3]   = 1;
    push(4'b1000, 8'h33);
    REQ      = 4'b1000;
    err_seen = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 60; i++) begin
      step();
      if (ERR === 1'b1) begin
        err_seen = 1'b1;
        break;
      end
    end
    check("to_err_seen", 32'(err_seen), 32'h1);
    check("to_err_delay", cyc - rise_cyc, TO_CYCLES);
    step();
    check("to_err_pulse", 32'(ERR), 32'h0);
    check("to_busy", 32'(BUSY), 32'h0);
    check("to_sb_empty", exp_q.size(), 0);
`else
    for (int i = 0; i < 60; i++) begin
      step();
      if (ERR !== 1'b0) err_seen = 1'b1;
    end
    check("stuck_busy", 32'(BUSY), 32'h1);
    check("stuck_err", 32'(err_seen), 32'h0);
    TBRE = 1'b0;
    step();
    TBRE = 1'b1;
    wait_done(20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
